dfr_sequencer: RTL and testbench
================================

Name: dfr_sequencer

Overview:
Control FSM that runs one DFR inference pass after software writes the CTRL start bit. It walks the input sample memory, feeds each step into the reservoir, and stores test-phase reservoir outputs into the history memory. At the end of each test sample it computes the weight·history dot product and writes the result into the DFR output memory. It sits inside the DFR core top, between the AXI config registers and memories and the reservoir datapath, and drives the top-level busy.

Parameters:
DATA_WIDTH, 32, width of sample, reservoir, weight and output words
ADDR_WIDTH, 16, word-address width of all memory ports
NUM_VIRTUAL_NODES, 100, length of the dot product per sample (NV)
CNT_WIDTH, 32, width of configuration counts

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from the CTRL register
num_init_samples  in  CNT_WIDTH  warm-up samples: driven through the reservoir, not stored
num_test_samples  in  CNT_WIDTH  samples stored and scored
num_steps_per_sample  in  CNT_WIDTH  reservoir steps per sample (S)
busy  out  1  high from the accepted start until done
done  out  1  one-cycle completion pulse
cfg_err  out  1  sticky; set when S < NV at start; cleared by the next accepted start
in_mem_addr  out  ADDR_WIDTH  input memory read address; read data valid 1 cycle later
in_mem_rdata  in  DATA_WIDTH  input memory read data
res_din  out  DATA_WIDTH  reservoir step input
res_din_valid  out  1  one-cycle step request
res_dout  in  DATA_WIDTH  reservoir step result
res_dout_valid  in  1  result strobe; arrives any number of cycles after the request (≥1)
hist_wen / hist_waddr / hist_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  history memory write port
hist_raddr  out  ADDR_WIDTH  history memory read address; 1-cycle latency
hist_rdata  in  DATA_WIDTH  history memory read data
w_mem_addr  out  ADDR_WIDTH  weight memory read address; 1-cycle latency
w_mem_rdata  in  DATA_WIDTH  weight memory read data
out_wen / out_waddr / out_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  output memory write port

Behaviour:
- Reset (asynchronous, at any time, including mid-run):
  - FSM returns to IDLE.
  - All outputs, counters and the accumulator go to 0.
  - Any reservoir result still in flight is ignored.
- Counters:
  - g = global step index, 0..(I+T)·S−1, where I = num_init_samples and T = num_test_samples.
  - h = history index = g − I·S.
  - t = test sample index.
  - k = node index.
- States:
  - IDLE: start with busy=0 latches the config, clears cfg_err and g, h, t.
    - I+T=0 or S=0: go to DONE.
    - S<NV: set cfg_err, go to DONE.
    - Otherwise go to FETCH.
    - start while busy=1 is ignored.
  - FETCH: in_mem_addr=g; go to DRIVE next cycle.
  - DRIVE: res_din=in_mem_rdata, res_din_valid=1 for exactly 1 cycle; go to WAIT_RES.
  - WAIT_RES: hold until res_dout_valid.
    - If g ≥ I·S, write res_dout to hist_waddr=h in the same cycle (hist_wen=1).
    - If the step is the last of a test sample, go to DOT; otherwise g++ (and h++ in test phase) and go to FETCH.
    - Init-phase steps never write.
  - DOT: for k=0..NV−1 on consecutive cycles, drive hist_raddr = t·S + S−NV + k and w_mem_addr = k. One cycle later the accumulator += signed(hist_rdata)·signed(w_mem_rdata).
    - Accumulator is 2·DATA_WIDTH signed, cleared on DOT entry.
    - After NV issue cycles plus 1 drain cycle, go to WRITE_OUT.
  - WRITE_OUT: out_wen=1, out_waddr=t, out_wdata = accumulator[DATA_WIDTH−1:0] (truncating, no saturation).
    - If t = T−1, go to DONE.
    - Otherwise t++, g++, h++, go to FETCH.
  - DONE: done=1 for 1 cycle, busy drops in the same cycle; return to IDLE.
- Timing:
  - busy rises the cycle after an accepted start.
  - Per step: 2 cycles + reservoir latency.
  - Per test sample, additionally NV+2 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap is not detected (software limits sizes).
- Only the last NV history words of each sample feed the dot product.
- A res_dout_valid outside WAIT_RES is ignored.

Test Plan:
- NV=4, I=0, T=1, S=4; inputs 10,20,30,40; reservoir model returns din+1 after 3 cycles; weights 1,2,3,4 -> history[0..3]=11,21,31,41; out[0]=11+42+93+164=310; one done pulse; busy low afterwards.
- NV=4, I=1, T=1, S=4; inputs 0..7; same model -> exactly 4 history writes at addresses 0..3 with data 5,6,7,8; no writes during the first 4 steps; out[0]=5+12+21+32=70.
- NV=4, I=0, T=2, S=6; inputs all 1; model returns din; weights all 2 -> out[0]=8, out[1]=8; second DOT reads hist addresses 8..11.
- S=3 with NV=4 -> cfg_err=1, done pulse within 2 cycles of start, no memory or reservoir activity; a following valid start clears cfg_err.
- Negative values: input −5, weight 3, NV=1, S=1, T=1 -> out[0]=−15 (0xFFFFFFF1 for 1:1 model).
- start pulsed while busy ignored (single done); ARESETN low mid-WAIT_RES -> all outputs 0 immediately, the late res_dout_valid is ignored, and a subsequent start completes normally.

Source files
------------

// File: rtl/dfr_sequencer.sv
// Control FSM for one DFR inference pass: walks the input memory through the reservoir,
// records test-phase reservoir outputs in history, and scores each test sample with a dot product.
module dfr_sequencer #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 16,
    parameter int NUM_VIRTUAL_NODES = 100,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_init_samples,
    input  logic [CNT_WIDTH-1:0]  num_test_samples,
    input  logic [CNT_WIDTH-1:0]  num_steps_per_sample,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [ADDR_WIDTH-1:0] in_mem_addr,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic [DATA_WIDTH-1:0] res_din,
    output logic                  res_din_valid,
    input  logic [DATA_WIDTH-1:0] res_dout,
    input  logic                  res_dout_valid,
    output logic                  hist_wen,
    output logic [ADDR_WIDTH-1:0] hist_waddr,
    output logic [DATA_WIDTH-1:0] hist_wdata,
    output logic [ADDR_WIDTH-1:0] hist_raddr,
    input  logic [DATA_WIDTH-1:0] hist_rdata,
    output logic [ADDR_WIDTH-1:0] w_mem_addr,
    input  logic [DATA_WIDTH-1:0] w_mem_rdata,
    output logic                  out_wen,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic [DATA_WIDTH-1:0] out_wdata
);

    localparam int K_W   = $clog2(NUM_VIRTUAL_NODES + 1);
    localparam int ACC_W = 2 * DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0]  NV_C    = CNT_WIDTH'(NUM_VIRTUAL_NODES);
    localparam logic [CNT_WIDTH-1:0]  ONE_C   = CNT_WIDTH'(1);
    localparam logic [K_W-1:0]        NV_K    = K_W'(NUM_VIRTUAL_NODES);
    localparam logic [K_W-1:0]        ONE_K   = K_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] NV_M1_A = ADDR_WIDTH'(NUM_VIRTUAL_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRIVE,
        S_WAIT_RES,
        S_DOT,
        S_WRITE_OUT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  init_q, init_d;
    logic [CNT_WIDTH-1:0]  test_q, test_d;
    logic [CNT_WIDTH-1:0]  steps_q, steps_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [ADDR_WIDTH-1:0] g_q, g_d;
    logic [ADDR_WIDTH-1:0] h_q, h_d;
    logic [CNT_WIDTH-1:0]  t_q, t_d;
    logic [CNT_WIDTH-1:0]  s_q, s_d;      // step index within the current sample
    logic [CNT_WIDTH-1:0]  smp_q, smp_d;  // sample index across init and test phases
    logic [K_W-1:0]        k_q, k_d;
    logic                  dot_vld_q, dot_vld_d;
    logic [ACC_W-1:0]      acc_q, acc_d;

    logic                  test_phase;
    logic                  last_step;
    logic [ACC_W-1:0]      hist_ext, w_ext, prod;

    // Sign-extending both operands to the accumulator width makes the truncated
    // unsigned product equal to the signed product modulo 2^ACC_W.
    assign hist_ext = {{DATA_WIDTH{hist_rdata[DATA_WIDTH-1]}}, hist_rdata};
    assign w_ext    = {{DATA_WIDTH{w_mem_rdata[DATA_WIDTH-1]}}, w_mem_rdata};
    assign prod     = hist_ext * w_ext;

    assign test_phase = (smp_q >= init_q);
    assign last_step  = (s_q == steps_q - ONE_C);

    // NOTE: every variable assigned in this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        test_d    = test_q;
        steps_d   = steps_q;
        cfg_err_d = cfg_err_q;
        g_d       = g_q;
        h_d       = h_q;
        t_d       = t_q;
        s_d       = s_q;
        smp_d     = smp_q;
        k_d       = k_q;
        dot_vld_d = 1'b0;
        acc_d     = dot_vld_q ? acc_q + prod : acc_q;

        busy          = (state_q != S_IDLE) && (state_q != S_DONE);
        done          = 1'b0;
        in_mem_addr   = '0;
        res_din       = '0;
        res_din_valid = 1'b0;
        hist_wen      = 1'b0;
        hist_waddr    = '0;
        hist_wdata    = '0;
        hist_raddr    = '0;
        w_mem_addr    = '0;
        out_wen       = 1'b0;
        out_waddr     = '0;
        out_wdata     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    init_d    = num_init_samples;
                    test_d    = num_test_samples;
                    steps_d   = num_steps_per_sample;
                    cfg_err_d = 1'b0;
                    g_d       = '0;
                    h_d       = '0;
                    t_d       = '0;
                    s_d       = '0;
                    smp_d     = '0;
                    if ((num_init_samples == '0 && num_test_samples == '0) ||
                        num_steps_per_sample == '0) begin
                        state_d = S_DONE;
                    end else if (num_steps_per_sample < NV_C) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                in_mem_addr = g_q;
                state_d     = S_DRIVE;
            end

            S_DRIVE: begin
                res_din       = in_mem_rdata;
                res_din_valid = 1'b1;
                state_d       = S_WAIT_RES;
            end

            S_WAIT_RES: begin
                if (res_dout_valid) begin
                    if (test_phase) begin
                        hist_wen   = 1'b1;
                        hist_waddr = h_q;
                        hist_wdata = res_dout;
                    end
                    if (test_phase && last_step) begin
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_DOT;
                    end else if (last_step && smp_q == init_q - ONE_C && test_q == '0) begin
                        // Init-only run: nothing to score after the final warm-up step.
                        state_d = S_DONE;
                    end else begin
                        g_d = g_q + ONE_A;
                        if (test_phase) begin
                            h_d = h_q + ONE_A;
                        end
                        if (last_step) begin
                            s_d   = '0;
                            smp_d = smp_q + ONE_C;
                        end else begin
                            s_d = s_q + ONE_C;
                        end
                        state_d = S_FETCH;
                    end
                end
            end

            S_DOT: begin
                // h_q still points at the last step of the sample, so the final NV
                // history words start NV-1 entries below it.
                if (k_q < NV_K) begin
                    hist_raddr = h_q - NV_M1_A + ADDR_WIDTH'(k_q);
                    w_mem_addr = ADDR_WIDTH'(k_q);
                    dot_vld_d  = 1'b1;
                    k_d        = k_q + ONE_K;
                end else begin
                    state_d = S_WRITE_OUT;
                end
            end

            S_WRITE_OUT: begin
                out_wen   = 1'b1;
                out_waddr = ADDR_WIDTH'(t_q);
                out_wdata = acc_q[DATA_WIDTH-1:0];
                if (t_q == test_q - ONE_C) begin
                    state_d = S_DONE;
                end else begin
                    t_d     = t_q + ONE_C;
                    g_d     = g_q + ONE_A;
                    h_d     = h_q + ONE_A;
                    s_d     = '0;
                    smp_d   = smp_q + ONE_C;
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_err = cfg_err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            init_q    <= '0;
            test_q    <= '0;
            steps_q   <= '0;
            cfg_err_q <= 1'b0;
            g_q       <= '0;
            h_q       <= '0;
            t_q       <= '0;
            s_q       <= '0;
            smp_q     <= '0;
            k_q       <= '0;
            dot_vld_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            test_q    <= test_d;
            steps_q   <= steps_d;
            cfg_err_q <= cfg_err_d;
            g_q       <= g_d;
            h_q       <= h_d;
            t_q       <= t_d;
            s_q       <= s_d;
            smp_q     <= smp_d;
            k_q       <= k_d;
            dot_vld_q <= dot_vld_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_dfr_sequencer.sv
// Bench for dfr_sequencer: memory and reservoir models, table of runs with a write scoreboard,
// plus hand-written restart-while-busy and mid-run reset sequences.
module tb_dfr_sequencer;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NV = 4;
    localparam int CW = 32;

    typedef struct {
        int unsigned         init;
        int unsigned         test;
        int unsigned         steps;
        int unsigned         lat;
        bit                  plus_one;
        logic [DW-1:0]       in_base;
        logic [DW-1:0]       in_step;
        logic [NV-1:0][DW-1:0] w;
        logic [DW-1:0]       exp_out0;
        logic [DW-1:0]       exp_out1;
        bit                  exp_cfg_err;
        int                  restart_at;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_init_samples, num_test_samples, num_steps_per_sample;
    logic          busy, done, cfg_err;
    logic [AW-1:0] in_mem_addr;
    logic [DW-1:0] in_mem_rdata;
    logic [DW-1:0] res_din;
    logic          res_din_valid;
    logic [DW-1:0] res_dout;
    logic          res_dout_valid;
    logic          hist_wen;
    logic [AW-1:0] hist_waddr, hist_raddr;
    logic [DW-1:0] hist_wdata, hist_rdata;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_rdata;
    logic          out_wen;
    logic [AW-1:0] out_waddr;
    logic [DW-1:0] out_wdata;

    always #5 clk = ~clk;

    dfr_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VIRTUAL_NODES(NV), .CNT_WIDTH(CW)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .start(start),
        .num_init_samples(num_init_samples),
        .num_test_samples(num_test_samples),
        .num_steps_per_sample(num_steps_per_sample),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
        .in_mem_addr(in_mem_addr),
        .in_mem_rdata(in_mem_rdata),
        .res_din(res_din),
        .res_din_valid(res_din_valid),
        .res_dout(res_dout),
        .res_dout_valid(res_dout_valid),
        .hist_wen(hist_wen),
        .hist_waddr(hist_waddr),
        .hist_wdata(hist_wdata),
        .hist_raddr(hist_raddr),
        .hist_rdata(hist_rdata),
        .w_mem_addr(w_mem_addr),
        .w_mem_rdata(w_mem_rdata),
        .out_wen(out_wen),
        .out_waddr(out_waddr),
        .out_wdata(out_wdata)
    );

    // Memories with one-cycle read latency.
    logic [DW-1:0] in_mem   [64];
    logic [DW-1:0] w_mem    [NV];
    logic [DW-1:0] hist_mem [64];

    always @(posedge clk) begin
        in_mem_rdata <= in_mem[in_mem_addr[5:0]];
        w_mem_rdata  <= w_mem[w_mem_addr[1:0]];
        hist_rdata   <= hist_mem[hist_raddr[5:0]];
        if (hist_wen) hist_mem[hist_waddr[5:0]] <= hist_wdata;
    end

    // Reservoir model: result appears res_lat cycles after the request cycle (res_lat >= 2).
    // It has no reset, so a request in flight across a DUT reset still answers late.
    int unsigned   res_lat = 3;
    bit            res_plus = 1'b1;
    int unsigned   rcnt = 0;
    logic [DW-1:0] rdat = '0;

    function automatic logic [DW-1:0] res_model(input logic [DW-1:0] d, input bit plus);
        return plus ? d + 32'd1 : d;
    endfunction

    initial begin
        res_dout_valid = 1'b0;
        res_dout       = '0;
    end

    always @(posedge clk) begin
        res_dout_valid <= 1'b0;
        if (res_din_valid) begin
            rcnt <= res_lat - 1;
            rdat <= res_model(res_din, res_plus);
        end else if (rcnt != 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
                res_dout_valid <= 1'b1;
                res_dout       <= rdat;
            end
        end
    end

    int  checks = 0;
    int  errors = 0;
    int  done_cnt, req_cnt, hist_cnt, out_cnt;
    wr_t hist_q[$];
    wr_t out_q[$];
    logic [AW-1:0] dot_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_counters();
        done_cnt = 0;
        req_cnt  = 0;
        hist_cnt = 0;
        out_cnt  = 0;
    endtask

    // Advance to the next falling edge and run the write/read-address scoreboards.
    task automatic tick();
        wr_t e;
        logic [AW-1:0] a;
        @(negedge clk);
        if (done) done_cnt++;
        if (res_din_valid) req_cnt++;
        if (hist_wen) begin
            hist_cnt++;
            check("hist_write_expected", 64'(hist_q.size() != 0), 64'd1);
            if (hist_q.size() != 0) begin
                e = hist_q.pop_front();
                check("hist_waddr", 64'(hist_waddr), 64'(e.addr));
                check("hist_wdata", 64'(hist_wdata), 64'(e.data));
            end
        end
        if (out_wen) begin
            out_cnt++;
            check("out_write_expected", 64'(out_q.size() != 0), 64'd1);
            if (out_q.size() != 0) begin
                e = out_q.pop_front();
                check("out_waddr", 64'(out_waddr), 64'(e.addr));
                check("out_wdata", 64'(out_wdata), 64'(e.data));
            end
        end
        if (w_mem_addr == AW'(NV - 1)) begin
            check("dot_expected", 64'(dot_q.size() != 0), 64'd1);
            if (dot_q.size() != 0) begin
                a = dot_q.pop_front();
                check("dot_last_hist_raddr", 64'(hist_raddr), 64'(a));
            end
        end
    endtask

    task automatic setup(input vec_t v);
        for (int i = 0; i < 64; i++) in_mem[i] = v.in_base + v.in_step * DW'(i);
        for (int i = 0; i < NV; i++) w_mem[i] = v.w[i];
        res_lat              = v.lat;
        res_plus             = v.plus_one;
        num_init_samples     = CW'(v.init);
        num_test_samples     = CW'(v.test);
        num_steps_per_sample = CW'(v.steps);
    endtask

    // Must be entered right after a tick(), so start is sampled on the next rising edge.
    task automatic run_case(input string tag, input vec_t v);
        bit quiet;
        bit seen;
        int exp_cyc;
        int g;
        quiet = (v.init == 0 && v.test == 0) || v.steps == 0 || v.steps < NV;
        setup(v);
        hist_q.delete();
        out_q.delete();
        dot_q.delete();
        if (!quiet) begin
            for (int t = 0; t < int'(v.test); t++) begin
                for (int j = 0; j < int'(v.steps); j++) begin
                    g = (int'(v.init) + t) * int'(v.steps) + j;
                    hist_q.push_back(wr_t'{AW'(t * int'(v.steps) + j), res_model(in_mem[g], v.plus_one)});
                end
                dot_q.push_back(AW'(t * int'(v.steps) + int'(v.steps) - 1));
                out_q.push_back(wr_t'{AW'(t), (t == 0) ? v.exp_out0 : v.exp_out1});
            end
            exp_cyc = 1 + int'((v.init + v.test) * v.steps * (2 + v.lat)) + int'(v.test) * (NV + 2);
        end else begin
            exp_cyc = 1;
        end
        reset_counters();
        start = 1'b1;
        seen  = 1'b0;
        for (int c = 1; c <= 4000 && !seen; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                check({tag, "_busy_after_start"}, 64'(busy), 64'(!quiet));
                check({tag, "_cfg_err_after_start"}, 64'(cfg_err), 64'(v.exp_cfg_err));
            end
            if (v.restart_at != 0 && c == v.restart_at) start = 1'b1;
            if (v.restart_at != 0 && c == v.restart_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, 64'(c), 64'(exp_cyc));
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
        start = 1'b0;
        if (!seen) check({tag, "_done_seen"}, 64'd0, 64'd1);
        repeat (4) tick();
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_cfg_err_final"}, 64'(cfg_err), 64'(v.exp_cfg_err));
        check({tag, "_busy_final"}, 64'(busy), 64'd0);
        check({tag, "_res_requests"}, 64'(req_cnt), quiet ? 64'd0 : 64'((v.init + v.test) * v.steps));
        check({tag, "_hist_writes"}, 64'(hist_cnt), quiet ? 64'd0 : 64'(v.test * v.steps));
        check({tag, "_out_writes"}, 64'(out_cnt), quiet ? 64'd0 : 64'(v.test));
        check({tag, "_scoreboard_empty"}, 64'(hist_q.size() + out_q.size() + dot_q.size()), 64'd0);
    endtask

    vec_t vecs[7];
    vec_t v;
    bit   seen;

    initial begin
        //         I  T  S  L  +1    in_base          in_step  weights w3..w0                                exp0            exp1   err  restart
        vecs[0] = '{0, 1, 4, 3, 1'b1, 32'd10,          32'd10,  {32'd4, 32'd3, 32'd2, 32'd1},  32'd310,        32'd0, 1'b0, 0};
        vecs[1] = '{1, 1, 4, 3, 1'b1, 32'd0,           32'd1,   {32'd4, 32'd3, 32'd2, 32'd1},  32'd70,         32'd0, 1'b0, 0};
        vecs[2] = '{0, 2, 6, 3, 1'b0, 32'd1,           32'd0,   {32'd2, 32'd2, 32'd2, 32'd2},  32'd8,          32'd8, 1'b0, 0};
        vecs[3] = '{0, 1, 3, 3, 1'b1, 32'd1,           32'd1,   {32'd1, 32'd1, 32'd1, 32'd1},  32'd0,          32'd0, 1'b1, 0};
        vecs[4] = '{0, 1, 4, 2, 1'b0, 32'hFFFF_FFFB,   32'd0,   {32'd0, 32'd0, 32'd0, 32'd3},  32'hFFFF_FFF1,  32'd0, 1'b0, 0};
        vecs[5] = '{0, 0, 4, 3, 1'b1, 32'd1,           32'd1,   {32'd1, 32'd1, 32'd1, 32'd1},  32'd0,          32'd0, 1'b0, 0};
        vecs[6] = '{0, 1, 4, 4, 1'b1, 32'd10,          32'd10,  {32'd4, 32'd3, 32'd2, 32'd1},  32'd310,        32'd0, 1'b0, 6};

        rst_n = 1'b0;
        start = 1'b0;
        num_init_samples     = '0;
        num_test_samples     = '0;
        num_steps_per_sample = '0;
        for (int i = 0; i < 64; i++) hist_mem[i] = '0;
        reset_counters();
        repeat (3) tick();
        check("reset_ctrl", 64'({busy, done, cfg_err, res_din_valid, hist_wen, out_wen}), 64'd0);
        check("reset_addrs", 64'({in_mem_addr, hist_raddr, w_mem_addr, out_waddr}), 64'd0);
        check("reset_data", 64'({res_din, out_wdata}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_case($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while waiting on the reservoir; its late result must be ignored.
        v = vecs[0];
        v.lat = 10;
        setup(v);
        hist_q.delete();
        out_q.delete();
        dot_q.delete();
        reset_counters();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (res_din_valid) seen = 1'b1;
            else tick();
        end
        check("rst_first_request_seen", 64'(seen), 64'd1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", 64'({busy, done, cfg_err, res_din_valid, hist_wen, out_wen}), 64'd0);
        check("rst_async_addrs", 64'({in_mem_addr, hist_raddr, w_mem_addr, out_waddr}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("rst_late_result_ignored", 64'({hist_cnt[15:0], out_cnt[15:0], done_cnt[15:0]}), 64'd0);
        check("rst_idle_after", 64'(busy), 64'd0);

        run_case("after_reset", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
